// File: rtl/instruction_fetch_stage_pkg.sv
// instruction_fetch_stage_pkg: shared word type, reset/bubble defaults and branch/jump target helpers
package instruction_fetch_stage_pkg;
    localparam int unsigned XLEN = 32;
    typedef logic [XLEN-1:0] word_t;
    localparam word_t NOP_INSTR_DEF = 32'h0000_0000;
    localparam word_t RESET_PC_DEF  = 32'h0000_0000;
    // Word offset, sign-extended and scaled to bytes, relative to the ID-stage PC+4
    function automatic word_t branch_target(input word_t pc4, input logic [15:0] imm);
        return pc4 + {{14{imm[15]}}, imm, 2'b00};
    endfunction
    // Pseudo-direct: keeps the 256 MiB region of the ID-stage PC+4
    function automatic word_t jump_target(input word_t pc4, input logic [25:0] idx);
        return {pc4[31:28], idx, 2'b00};
    endfunction
endpackage

// File: rtl/instruction_fetch_stage_if.sv
// instruction_fetch_stage_if: instruction ROM bus plus IF/ID register outputs
//   imem_addr      fetch -> ROM, byte address of the word issued this cycle
//   imem_rdata     ROM -> fetch, word for the address presented the previous cycle
//   ifid_instr     fetched instruction handed to decode
//   ifid_pc_plus4  PC+4 of ifid_instr
//   ifid_valid     ifid_instr is a real instruction (0 = bubble)
interface instruction_fetch_stage_if;
    import instruction_fetch_stage_pkg::*;
    word_t imem_addr;
    word_t imem_rdata;
    word_t ifid_instr;
    word_t ifid_pc_plus4;
    logic  ifid_valid;
    modport master (output imem_addr, ifid_instr, ifid_pc_plus4, ifid_valid, input imem_rdata);
    modport slave  (input imem_addr, ifid_instr, ifid_pc_plus4, ifid_valid, output imem_rdata);
endinterface

// File: rtl/instruction_fetch_stage_skid_buffer.sv
// instruction_fetch_stage_skid_buffer: keeps the ROM word that arrives during a stall and selects the source word
//   clk, rst_n         clock, async active-low reset
//   i_redirect         squash any held word
//   i_stall            decode is holding; capture the in-flight ROM word
//   i_inflight_valid   imem_rdata carries a real word this cycle
//   i_rdata            ROM read data
//   o_src, o_src_valid source word for the IF/ID register and its validity
module instruction_fetch_stage_skid_buffer
    import instruction_fetch_stage_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  i_redirect,
    input  logic  i_stall,
    input  logic  i_inflight_valid,
    input  word_t i_rdata,
    output word_t o_src,
    output logic  o_src_valid
);
    logic  r_hold_valid;
    word_t r_hold_instr;
    // The synchronous ROM only presents a word for one cycle, so a stalled word must be parked here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_valid <= 1'b0;
            r_hold_instr <= '0;
        end else if (i_redirect) begin
            r_hold_valid <= 1'b0;
        end else if (i_stall) begin
            if (i_inflight_valid && !r_hold_valid) begin
                r_hold_instr <= i_rdata;
                r_hold_valid <= 1'b1;
            end
        end else begin
            r_hold_valid <= 1'b0;
        end
    end
    assign o_src       = r_hold_valid ? r_hold_instr : i_rdata;
    assign o_src_valid = r_hold_valid | i_inflight_valid;
endmodule

// File: rtl/instruction_fetch_stage.sv
// instruction_fetch_stage: PC, synchronous-ROM fetch and IF/ID register with stall and branch/jump redirect
//   clk, rst_n      clock, async active-low reset
//   i_stall         hold PC and IF/ID this cycle
//   i_branch_taken  branch in ID taken, offset i_branch_imm (words)
//   i_jump          jump in ID to i_jump_index; wins over a coincident branch
//   bus             ROM address/data and IF/ID outputs
module instruction_fetch_stage
    import instruction_fetch_stage_pkg::*;
#(
    parameter word_t RESET_PC  = RESET_PC_DEF,
    parameter word_t NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_stall,
    input  logic        i_branch_taken,
    input  logic [15:0] i_branch_imm,
    input  logic        i_jump,
    input  logic [25:0] i_jump_index,
    instruction_fetch_stage_if.master bus
);
    word_t r_pc, r_inflight_pc, r_ifid_instr, r_ifid_pc4;
    logic  r_inflight_valid, r_ifid_valid;
    word_t w_src, w_target;
    logic  w_src_valid, w_redirect;
    assign w_redirect = i_jump | i_branch_taken;
    assign w_target   = i_jump ? jump_target(r_ifid_pc4, i_jump_index) : branch_target(r_ifid_pc4, i_branch_imm);
    instruction_fetch_stage_skid_buffer u_skid (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_redirect       (w_redirect),
        .i_stall          (i_stall),
        .i_inflight_valid (r_inflight_valid),
        .i_rdata          (bus.imem_rdata),
        .o_src            (w_src),
        .o_src_valid      (w_src_valid)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc             <= RESET_PC;
            r_inflight_pc    <= '0;
            r_inflight_valid <= 1'b0;
            r_ifid_instr     <= NOP_INSTR;
            r_ifid_pc4       <= '0;
            r_ifid_valid     <= 1'b0;
        end else if (w_redirect) begin
            r_pc             <= w_target;
            r_inflight_valid <= 1'b0;
            r_ifid_instr     <= NOP_INSTR;
            r_ifid_valid     <= 1'b0;
        end else if (i_stall) begin
            // The word in flight is now parked in the skid buffer; the PC re-issues after release
            r_inflight_valid <= 1'b0;
        end else begin
            r_ifid_instr     <= w_src_valid ? w_src : NOP_INSTR;
            r_ifid_valid     <= w_src_valid;
            r_ifid_pc4       <= r_inflight_pc + 32'd4;
            r_inflight_pc    <= r_pc;
            r_inflight_valid <= 1'b1;
            r_pc             <= r_pc + 32'd4;
        end
    end
    assign bus.imem_addr     = r_pc;
    assign bus.ifid_instr    = r_ifid_instr;
    assign bus.ifid_pc_plus4 = r_ifid_pc4;
    assign bus.ifid_valid    = r_ifid_valid;
endmodule
